// File: rtl/pixel_stream_packer_if.sv
// Pixel/word payload types and the valid-only pixel stream interface
// that connects the median filter to the packer.
package pixel_stream_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

endpackage

interface pixel_valid_if;
    import pixel_stream_pkg::*;

    logic   valid;
    pixel_t pixel;

    modport master (output valid, pixel);
    modport slave  (input  valid, pixel);
endinterface

// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels into a dense 32-bit byte stream, buffers the words
// in a first-word-fall-through FIFO and presents them with keep/last framing.
module pixel_stream_packer
    import pixel_stream_pkg::*;
#(
    parameter int unsigned OUT_LEN    = 1079,
    parameter int unsigned OUT_HEIGHT = 719,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    pixel_valid_if.slave                        pixel_valid_if_i,
    output logic [31:0]                         m_data_o,
    output logic [3:0]                          m_keep_o,
    output logic                                m_last_o,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic                                frame_done_o,
    output logic                                overflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o
);

    localparam int unsigned TOTAL_PX = OUT_LEN * OUT_HEIGHT;
    localparam int unsigned PIX_W    = (TOTAL_PX > 1) ? $clog2(TOTAL_PX) : 1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    state_e             state_q, state_d;
    logic [23:0]        res_q, res_d, cur_res;
    logic [1:0]         rcnt_q, rcnt_d, cur_r;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic               last_px;
    logic               wr_req;
    word_t              wr_word;

    word_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, frame_done_q, overflow_q;
    logic               push, pop, full, drop;

    pixel_t             px;
    logic               px_valid;

    assign px       = pixel_valid_if_i.pixel;
    assign px_valid = pixel_valid_if_i.valid;

    // Packer state: FSM, residue bytes (byte 0 in [7:0]) and frame pixel counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            res_q   <= '0;
            rcnt_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rcnt_q  <= rcnt_d;
            pix_q   <= pix_d;
        end
    end

    // A FLUSH cycle empties the residue first, so a pixel in that cycle packs from r=0
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rcnt_d  = rcnt_q;
        pix_d   = pix_q;
        wr_req  = 1'b0;
        wr_word = '0;
        cur_res = res_q;
        cur_r   = rcnt_q;
        last_px = 1'b0;

        if (state_q == ST_FLUSH) begin
            wr_req       = 1'b1;
            wr_word.data = {8'h00, res_q};
            wr_word.last = 1'b1;
            unique case (rcnt_q)
                2'd1:    wr_word.keep = 4'b0001;
                2'd2:    wr_word.keep = 4'b0011;
                2'd3:    wr_word.keep = 4'b0111;
                default: wr_word.keep = 4'b0000;
            endcase
            cur_res = '0;
            cur_r   = '0;
            res_d   = '0;
            rcnt_d  = '0;
            state_d = ST_RUN;
        end

        if (px_valid) begin
            last_px = (pix_q == PIX_W'(TOTAL_PX - 1));
            pix_d   = last_px ? '0 : pix_q + PIX_W'(1);
            unique case (cur_r)
                2'd0: begin
                    res_d  = {px.blue, px.green, px.red};
                    rcnt_d = 2'd3;
                end
                2'd3: begin
                    wr_req       = 1'b1;
                    wr_word.data = {px.red, cur_res};
                    res_d        = {8'h00, px.blue, px.green};
                    rcnt_d       = 2'd2;
                end
                2'd2: begin
                    wr_req       = 1'b1;
                    wr_word.data = {px.green, px.red, cur_res[15:0]};
                    res_d        = {16'h0000, px.blue};
                    rcnt_d       = 2'd1;
                end
                default: begin
                    wr_req       = 1'b1;
                    wr_word.data = {px.blue, px.green, px.red, cur_res[7:0]};
                    res_d        = '0;
                    rcnt_d       = 2'd0;
                end
            endcase
            if (cur_r != 2'd0) begin
                wr_word.keep = 4'hF;
                wr_word.last = last_px && (rcnt_d == 2'd0);
            end
            if (last_px && (rcnt_d != 2'd0)) begin
                state_d = ST_FLUSH;
            end
        end
    end

    // FIFO control; a push into a full FIFO only survives if the head leaves this cycle
    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = valid_q && m_ready_i;
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_word;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            valid_q      <= (count_d != '0);
            frame_done_q <= pop && mem_q[rd_ptr_q].last;
            overflow_q   <= overflow_q | drop;
        end
    end

    assign m_data_o     = mem_q[rd_ptr_q].data;
    assign m_keep_o     = mem_q[rd_ptr_q].keep;
    assign m_last_o     = mem_q[rd_ptr_q].last;
    assign m_valid_o    = valid_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;
    assign level_o      = count_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench: three packer configurations share one pixel stream and
// are compared every cycle against a byte-queue / word-queue behavioural model.
module tb_pixel_stream_packer;
    import pixel_stream_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_valid_if pif ();

    logic        rdy     [NDUT];
    logic [31:0] m_data  [NDUT];
    logic [3:0]  m_keep  [NDUT];
    logic        m_last  [NDUT];
    logic        m_valid [NDUT];
    logic        fdone   [NDUT];
    logic        ovf     [NDUT];
    logic [2:0]  level0, level1;
    logic [4:0]  level2;

    // A: 3x1 frame, depth 4 (flush keep 0001).  B: 4x1, depth 4 (no flush).
    // C: 3x3, depth 16 (flush keep 0111, same residue as the full-size frame).
    pixel_stream_packer #(.OUT_LEN(3), .OUT_HEIGHT(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .pixel_valid_if_i(pif),
        .m_data_o(m_data[0]), .m_keep_o(m_keep[0]), .m_last_o(m_last[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(rdy[0]), .frame_done_o(fdone[0]),
        .overflow_o(ovf[0]), .level_o(level0));

    pixel_stream_packer #(.OUT_LEN(4), .OUT_HEIGHT(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .pixel_valid_if_i(pif),
        .m_data_o(m_data[1]), .m_keep_o(m_keep[1]), .m_last_o(m_last[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(rdy[1]), .frame_done_o(fdone[1]),
        .overflow_o(ovf[1]), .level_o(level1));

    pixel_stream_packer #(.OUT_LEN(3), .OUT_HEIGHT(3), .FIFO_DEPTH(16)) dut_c (
        .clk(clk), .rst(rst), .pixel_valid_if_i(pif),
        .m_data_o(m_data[2]), .m_keep_o(m_keep[2]), .m_last_o(m_last[2]),
        .m_valid_o(m_valid[2]), .m_ready_i(rdy[2]), .frame_done_o(fdone[2]),
        .overflow_o(ovf[2]), .level_o(level2));

    int unsigned total_px [NDUT] = '{3, 4, 9};
    int unsigned depth    [NDUT] = '{4, 4, 16};

    logic [7:0]  bq   [NDUT][$];
    word_t       fq   [NDUT][$];
    word_t       macc [NDUT][$];
    word_t       dacc [NDUT][$];
    int unsigned pcnt       [NDUT];
    bit          flush_pend [NDUT];
    bit          e_ovf      [NDUT];
    bit          e_fd       [NDUT];
    int          fd_seen    [NDUT];
    logic [7:0]  gold [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, i, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_level(input int i);
        case (i)
            0:       return 64'(level0);
            1:       return 64'(level1);
            default: return 64'(level2);
        endcase
    endfunction

    function automatic pixel_t mkpx(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        pixel_t p;
        p.red = r; p.green = g; p.blue = b;
        return p;
    endfunction

    function automatic pixel_t seqpx(input int k);
        return mkpx(8'(3 * k + 1), 8'(3 * k + 2), 8'(3 * k + 3));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDUT; i++) begin
            bq[i].delete(); fq[i].delete(); macc[i].delete(); dacc[i].delete();
            pcnt[i] = 0; flush_pend[i] = 0; e_ovf[i] = 0; e_fd[i] = 0; fd_seen[i] = 0;
        end
        gold.delete();
    endtask

    // One clock of the behavioural model: bytes queue up in stream order,
    // every 4 bytes form a word, a frame's leftover bytes go out one cycle later.
    task automatic model_advance(input int i, input bit v, input pixel_t p);
        word_t w;
        bit    have, pop, last_px, fd_next;
        int    n;
        have = 0;
        w    = '0;
        pop  = (fq[i].size() > 0) && rdy[i];
        if (flush_pend[i]) begin
            n = bq[i].size();
            for (int k = 0; k < n; k++) w.data[8*k +: 8] = bq[i][k];
            w.keep = 4'((1 << n) - 1);
            w.last = 1'b1;
            bq[i].delete();
            flush_pend[i] = 0;
            have = 1;
        end
        if (v) begin
            bq[i].push_back(p.red);
            bq[i].push_back(p.green);
            bq[i].push_back(p.blue);
            pcnt[i]++;
            last_px = (pcnt[i] == total_px[i]);
            if (last_px) pcnt[i] = 0;
            if (bq[i].size() >= 4) begin
                w = '0;
                for (int k = 0; k < 4; k++) w.data[8*k +: 8] = bq[i].pop_front();
                w.keep = 4'hF;
                w.last = last_px && (bq[i].size() == 0);
                have = 1;
            end
            if (last_px && (bq[i].size() != 0)) flush_pend[i] = 1;
        end
        fd_next = pop && fq[i][0].last;
        if (pop) macc[i].push_back(fq[i].pop_front());
        if (have) begin
            if (fq[i].size() < int'(depth[i])) fq[i].push_back(w);
            else e_ovf[i] = 1;
        end
        e_fd[i] = fd_next;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NDUT; i++) begin
            chk("m_valid", i, 64'(m_valid[i]), 64'(fq[i].size() > 0));
            chk("level", i, get_level(i), 64'(fq[i].size()));
            chk("overflow", i, 64'(ovf[i]), 64'(e_ovf[i]));
            chk("frame_done", i, 64'(fdone[i]), 64'(e_fd[i]));
            if (fdone[i] === 1'b1) fd_seen[i]++;
            if (fq[i].size() > 0) begin
                chk("m_data", i, 64'(m_data[i]), 64'(fq[i][0].data));
                chk("m_keep", i, 64'(m_keep[i]), 64'(fq[i][0].keep));
                chk("m_last", i, 64'(m_last[i]), 64'(fq[i][0].last));
            end
        end
    endtask

    // Drive one cycle from a negedge, advance the model, compare at the next negedge
    task automatic step(input bit v, input pixel_t p);
        word_t dw;
        pif.valid = v;
        pif.pixel = p;
        if (v) begin
            gold.push_back(p.red); gold.push_back(p.green); gold.push_back(p.blue);
        end
        for (int i = 0; i < NDUT; i++) begin
            if (m_valid[i] && rdy[i]) begin
                dw.data = m_data[i]; dw.keep = m_keep[i]; dw.last = m_last[i];
                dacc[i].push_back(dw);
            end
            model_advance(i, v, p);
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_valid", i, 64'(m_valid[i]), 64'd0);
        chk("rst_level", i, get_level(i), 64'd0);
        chk("rst_data", i, 64'(m_data[i]), 64'd0);
        chk("rst_keep", i, 64'(m_keep[i]), 64'd0);
        chk("rst_last", i, 64'(m_last[i]), 64'd0);
        chk("rst_ovf", i, 64'(ovf[i]), 64'd0);
        chk("rst_fdone", i, 64'(fdone[i]), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pif.valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) chk_zero(i);
    endtask

    task automatic chk_word(input string name, input int i, input word_t w,
                            input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({name, "_data"}, i, 64'(w.data), 64'(d));
        chk({name, "_keep"}, i, 64'(w.keep), 64'(k));
        chk({name, "_last"}, i, 64'(w.last), 64'(l));
    endtask

    pixel_t sc [4];

    initial begin
        int          sent, nbad, nlast, frames;
        logic [7:0]  got [$];
        word_t       lw;

        sc[0] = mkpx(8'h11, 8'h22, 8'h33);
        sc[1] = mkpx(8'h44, 8'h55, 8'h66);
        sc[2] = mkpx(8'h77, 8'h88, 8'h99);
        sc[3] = mkpx(8'hAA, 8'hBB, 8'hCC);
        rdy = '{1'b1, 1'b1, 1'b1};
        pif.valid = 1'b0;
        pif.pixel = '0;

        // Directed frames: A flushes (pixel 4 lands in A's FLUSH cycle), B ends word-aligned
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, sc[k]);
        idle(6);
        chk("a_words", 0, 64'(macc[0].size()), 64'd3);
        chk("b_words", 1, 64'(macc[1].size()), 64'd3);
        if (macc[0].size() >= 3) begin
            chk_word("a_w0", 0, macc[0][0], 32'h44332211, 4'hF, 1'b0);
            chk_word("a_w1", 0, macc[0][1], 32'h88776655, 4'hF, 1'b0);
            chk_word("a_w2", 0, macc[0][2], 32'h00000099, 4'h1, 1'b1);
        end
        if (macc[1].size() >= 3) begin
            chk_word("b_w0", 1, macc[1][0], 32'h44332211, 4'hF, 1'b0);
            chk_word("b_w2", 1, macc[1][2], 32'hCCBBAA99, 4'hF, 1'b1);
        end
        chk("a_frame_done_cnt", 0, 64'(fd_seen[0]), 64'd1);
        chk("b_frame_done_cnt", 1, 64'(fd_seen[1]), 64'd1);

        // Random gaps and backpressure; C always ready for the golden byte check
        sent = 0;
        for (int c = 0; c < 3000 && !(sent >= 120 && pcnt[2] == 0); c++) begin
            rdy[0] = ($urandom_range(3) != 0);
            rdy[1] = ($urandom_range(3) != 0);
            rdy[2] = 1'b1;
            if ($urandom_range(1) == 1) begin
                step(1'b1, mkpx(8'($urandom), 8'($urandom), 8'($urandom)));
                sent++;
            end else begin
                step(1'b0, '0);
            end
        end
        rdy = '{1'b1, 1'b1, 1'b1};
        idle(20);
        got.delete();
        nlast = 0;
        foreach (dacc[2][w]) begin
            for (int k = 0; k < 4; k++)
                if (dacc[2][w].keep[k]) got.push_back(dacc[2][w].data[8*k +: 8]);
            if (dacc[2][w].last) nlast++;
        end
        chk("gold_len", 2, 64'(got.size()), 64'(gold.size()));
        nbad = 0;
        for (int k = 0; k < got.size() && k < gold.size(); k++)
            if (got[k] !== gold[k]) nbad++;
        chk("gold_bytes", 2, 64'(nbad), 64'd0);
        frames = gold.size() / 27;
        chk("c_words", 2, 64'(dacc[2].size()), 64'(frames * 7));
        chk("c_lasts", 2, 64'(nlast), 64'(frames));
        if (dacc[2].size() > 0) begin
            lw = dacc[2][dacc[2].size() - 1];
            chk("c_final_keep", 2, 64'(lw.keep), 64'h7);
            chk("c_final_last", 2, 64'(lw.last), 64'd1);
        end

        // Overflow on A; B fills exactly, then push+pop while full
        do_reset();
        rdy = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) step(1'b1, seqpx(k));
        idle(2);
        chk("ovf_level_a", 0, get_level(0), 64'd4);
        chk("ovf_set_a", 0, 64'(ovf[0]), 64'd1);
        chk("full_level_b", 1, get_level(1), 64'd4);
        chk("full_no_ovf_b", 1, 64'(ovf[1]), 64'd0);
        rdy[1] = 1'b1;
        step(1'b1, seqpx(6));
        chk("pushpop_level_b", 1, get_level(1), 64'd4);
        chk("pushpop_no_ovf_b", 1, 64'(ovf[1]), 64'd0);
        chk("ovf_sticky_a", 0, 64'(ovf[0]), 64'd1);
        rdy = '{1'b1, 1'b1, 1'b1};
        idle(10);
        chk("ovf_sticky_after_drain_a", 0, 64'(ovf[0]), 64'd1);
        chk("drain_count_a", 0, 64'(dacc[0].size()), 64'd4);
        if (dacc[0].size() >= 4) begin
            chk_word("drain_w0", 0, dacc[0][0], 32'h04030201, 4'hF, 1'b0);
            chk_word("drain_w2", 0, dacc[0][2], 32'h00000009, 4'h1, 1'b1);
            chk_word("drain_w3", 0, dacc[0][3], 32'h0D0C0B0A, 4'hF, 1'b0);
        end

        // Asynchronous reset mid-frame with three words queued in A
        do_reset();
        rdy = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) step(1'b1, sc[k]);
        idle(2);
        chk("pre_reset_level_a", 0, get_level(0), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk_zero(0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rdy = '{1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) step(1'b1, sc[k]);
        idle(4);
        if (dacc[0].size() >= 1)
            chk_word("post_reset_w0", 0, dacc[0][0], 32'h44332211, 4'hF, 1'b0);
        else
            chk("post_reset_words", 0, 64'(dacc[0].size()), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Sits directly downstream of the median filter.
- Consumes its filtered RGB pixel stream (valid-only, no backpressure). Each output frame is (IMAGE_LEN-1) x (IMAGE_HEIGHT-1) pixels.
- Packs the 24-bit pixels into a dense 32-bit byte stream and buffers the words in a FIFO.
- Presents the words on a ready/valid master port with keep/last framing, for the DMA/frame-writer.

Parameters:
- OUT_LEN, 1079, output pixels per line (median filter IMAGE_LEN-1).
- OUT_HEIGHT, 719, output lines per frame (median filter IMAGE_HEIGHT-1).
- FIFO_DEPTH, 16, word FIFO entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pixel_valid_if_i  pixel_valid_if.slave  valid + pixel_t {red,green,blue}  filtered pixel stream; no ready
- m_data_o  out  32  packed bytes; byte0 = [7:0]
- m_keep_o  out  4  byte enables, contiguous from bit 0
- m_last_o  out  1  final word of frame
- m_valid_o  out  1  word available
- m_ready_i  in  1  consumer accepts word
- frame_done_o  out  1  one-cycle pulse when last word is accepted
- overflow_o  out  1  sticky; a word was dropped because the FIFO was full
- level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-frame):
  - m_valid_o=0, m_last_o=0, m_keep_o=0, m_data_o=0, frame_done_o=0, overflow_o=0, level_o=0.
  - Residue, pixel counter and FIFO are cleared. Partial frame is discarded.
- Byte order: each pixel contributes bytes red, green, blue in that order to a continuous byte stream. Byte k of a word goes to m_data_o[8k+7:8k].
- Residue r (0..3 held bytes), residue register holds up to 3 bytes. On each accepted pixel:
  - r=0 -> r=3, no write.
  - r=3 -> write full word, r=2.
  - r=2 -> write full word, r=1.
  - r=1 -> write full word, r=0.
  - Full words have keep=4'b1111.
- Pixel counter counts 0..OUT_LEN*OUT_HEIGHT-1 and wraps on the last pixel.
- Last pixel of frame:
  - If r after that pixel is 0, the word written that cycle carries last=1.
  - Otherwise its full word (if any) carries last=0, and the FSM enters FLUSH for exactly one cycle.
  - In FLUSH, the residue is written as one word with keep = low r bits set (2'b?? -> 4'b0001 / 0011 / 0111), unused bytes 0, last=1.
- Next frame:
  - r is 0 at the start of the next frame. A pixel arriving during FLUSH is accepted normally (r 0->3, no write), so at most one FIFO write occurs per cycle.
- FSM states: RUN, FLUSH. FLUSH always returns to RUN after one cycle.
- FIFO: first-word-fall-through.
  - A write at edge t makes m_valid_o=1 from cycle t+1.
  - Pop occurs when m_valid_o && m_ready_i.
  - Simultaneous push and pop when full is accepted; level is unchanged.
  - Push while full with no pop: the word is dropped, overflow_o set until reset, and the pixel counter/residue still advance so framing stays aligned.
- m_data_o, m_keep_o and m_last_o are stable while m_valid_o && !m_ready_i.
- frame_done_o = registered pulse of the handshake on a word with last=1.
- Latency: pixel to m_valid_o is 1 cycle when the FIFO is empty and the pixel completes a word. A flush word appears 2 cycles after the last pixel.

Test Plan:
- OUT_LEN=3, OUT_HEIGHT=1, m_ready_i=1; pixels (11,22,33), (44,55,66), (77,88,99) hex, consecutive -> words:
  - 0x44332211 keep F last 0
  - 0x88776655 keep F last 0
  - 0x00000099 keep 1 last 1
  - frame_done_o pulses once.
- OUT_LEN=4, OUT_HEIGHT=1, same pixels plus (AA,BB,CC) -> three words, the third 0xCCBBAA99 keep F last 1. No FLUSH word.
- Default params, random pixel gaps, m_ready_i=1 -> 581851 words. Last word keep 4'b0111, last=1. Byte stream equals a golden RGB concatenation.
- FIFO_DEPTH=4, m_ready_i=0, 8 back-to-back pixels (6 words) -> level_o saturates at 4, overflow_o=1 and stays 1. Releasing ready delivers the first 4 words unchanged.
- Full FIFO with m_ready_i=1 while a pixel completes a word -> no overflow, level_o constant.
- Reset asserted mid-frame with level_o=3 -> outputs zero immediately (async). The next frame packs from r=0 and the first word matches the scenario 1 pattern.
